// File: rtl/marquee_pkg.sv
// Shared definitions for the marquee frame loader.
//   state_e          : loader FSM states
//   BLANK_DIGIT      : digit code driven to the scan driver for an unlit position
//   DIGITS_PER_FRAME : number of digit positions in one display window
//   blank_if_invalid : maps digit codes 11-15 onto BLANK_DIGIT
package marquee_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StScroll,
      StPause
   } state_e;

   localparam logic [3:0]  BLANK_DIGIT      = 4'hA;
   localparam int unsigned DIGITS_PER_FRAME = 8;

   function automatic logic [3:0] blank_if_invalid(input logic [3:0] digit);
      return (digit > 4'd10) ? BLANK_DIGIT : digit;
   endfunction

endpackage

// File: rtl/marquee_tick_gen.sv
// Scroll-step timebase: counts 0..TICK_DIV-1 while enabled and pulses for one cycle
// on the terminal count, wrapping back to 0. clear forces the count to 0 and
// suppresses the pulse.
// Ports:
//   clk    : clock
//   enable : advance the count this cycle
//   clear  : synchronous clear (has priority over enable)
//   pulse  : high for the cycle in which the terminal count is consumed
module marquee_tick_gen #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic enable,
   input  logic clear,
   output logic pulse
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LastCount = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= (cnt_q == LastCount) ? '0 : cnt_q + CW'(1);
      end
   end

   assign pulse = enable && !clear && (cnt_q == LastCount);

endmodule

// File: rtl/marquee_frame_loader.sv
// Marquee frame loader: accepts a digit message as a valid/ready stream, then scrolls
// it leftwards through an eight-digit window, one position per TICK_DIV clocks.
// Build option: define MARQUEE_BLANK_GAP_EN to insert eight blanks between message
// repetitions; otherwise the message wraps seamlessly.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : digit beat offered
//   in_digit    : digit code 0-9, 10 = blank (11-15 stored as blank)
//   in_last     : final digit of the message
//   in_ready    : a beat is accepted this cycle when in_valid is also high
//   run         : 1 = scroll, 0 = pause
//   flush       : discard the message and return to idle (highest priority)
//   digits_out  : eight nibbles, [31:28] leftmost .. [3:0] rightmost
//   frame_valid : digits_out holds a message window
module marquee_frame_loader
   import marquee_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned MAX_LEN  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [3:0]  in_digit,
   input  logic        in_last,
   output logic        in_ready,
   input  logic        run,
   input  logic        flush,
   output logic [31:0] digits_out,
   output logic        frame_valid
);

   // IW covers len and pos, including the optional eight-digit gap.
   localparam int unsigned IW = $clog2(MAX_LEN + DIGITS_PER_FRAME + 1);
   localparam int unsigned BW = $clog2(MAX_LEN);
   localparam int unsigned FW = 4 * DIGITS_PER_FRAME;

   state_e          state_q, state_d;
   logic [IW-1:0]   len_q, len_d;
   logic [IW-1:0]   pos_q, pos_d;
   logic [3:0]      msg_buf [MAX_LEN];
   logic [FW-1:0]   window;
   logic [IW-1:0]   eff_len;
   logic [IW-1:0]   idx;
   logic            accept;
   logic            scroll_start;
   logic            tick;
   logic            tick_en;
   logic            tick_clr;

`ifdef MARQUEE_BLANK_GAP_EN
   assign eff_len = len_q + IW'(DIGITS_PER_FRAME);
`else
   assign eff_len = len_q;
`endif

   assign in_ready = ((state_q == StIdle) || (state_q == StLoad)) && !flush;
   assign accept   = in_valid && in_ready;

   assign tick_en  = (state_q == StScroll) && run;
   assign tick_clr = rst || flush || scroll_start;

   marquee_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .enable(tick_en),
      .clear (tick_clr),
      .pulse (tick)
   );

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      pos_d        = pos_q;
      scroll_start = 1'b0;
      if (flush) begin
         state_d = StIdle;
         len_d   = '0;
         pos_d   = '0;
      end else begin
         unique case (state_q)
            StIdle, StLoad: begin
               if (accept) begin
                  len_d = len_q + IW'(1);
                  // A full buffer ends the message even without in_last.
                  if (in_last || (len_q + IW'(1) == IW'(MAX_LEN))) begin
                     state_d      = StScroll;
                     pos_d        = '0;
                     scroll_start = 1'b1;
                  end else begin
                     state_d = StLoad;
                  end
               end
            end
            StScroll: begin
               if (!run) begin
                  state_d = StPause;
               end else if (tick) begin
                  pos_d = (pos_q + IW'(1) == eff_len) ? '0 : pos_q + IW'(1);
               end
            end
            StPause: begin
               if (run) begin
                  state_d = StScroll;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Walk the window left to right, wrapping the sequence index at eff_len.
   always_comb begin
      window = {DIGITS_PER_FRAME{BLANK_DIGIT}};
      idx    = pos_q;
      for (int j = 0; j < DIGITS_PER_FRAME; j++) begin
         if (idx < len_q) begin
            window[4*(DIGITS_PER_FRAME-1-j) +: 4] = msg_buf[idx[BW-1:0]];
         end
         idx = (idx + IW'(1) == eff_len) ? '0 : idx + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         len_q   <= '0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         pos_q   <= pos_d;
      end
   end

   // Buffer contents survive reset; len alone decides what is visible.
   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         msg_buf[len_q[BW-1:0]] <= blank_if_invalid(in_digit);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         digits_out  <= {DIGITS_PER_FRAME{BLANK_DIGIT}};
         frame_valid <= 1'b0;
      end else if ((state_q == StScroll) || (state_q == StPause)) begin
         digits_out  <= window;
         frame_valid <= 1'b1;
      end else begin
         digits_out  <= {DIGITS_PER_FRAME{BLANK_DIGIT}};
         frame_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_marquee_frame_loader.sv
// Randomized scoreboard bench for marquee_frame_loader (TICK_DIV=4, MAX_LEN=16).
// The reference model keeps the message as a queue and derives each window with
// modulo arithmetic; expected registered outputs are queued at each clock edge and
// compared by an independent monitor on the falling edge.
module tb_marquee_frame_loader;

   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned MAX_LEN  = 16;
`ifdef MARQUEE_BLANK_GAP_EN
   localparam int GAP = 8;
`else
   localparam int GAP = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_digit;
   logic        in_last;
   logic        in_ready;
   logic        run;
   logic        flush;
   logic [31:0] digits_out;
   logic        frame_valid;

   marquee_frame_loader #(
      .TICK_DIV(TICK_DIV),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_digit   (in_digit),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .run        (run),
      .flush      (flush),
      .digits_out (digits_out),
      .frame_valid(frame_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] digits;
      logic        fv;
   } exp_t;

   exp_t       exp_q [$];
   int         n_checks = 0;
   int         n_pass   = 0;

   // Reference model state
   logic [3:0] m_msg [$];
   bit         m_known  = 0;
   bit         m_show   = 0;
   bit         m_paused = 0;
   int         m_pos    = 0;
   int         m_cnt    = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
   endfunction

   function automatic logic [31:0] model_window();
      logic [31:0] w;
      int          l;
      int          k;
      w = '0;
      l = m_msg.size() + GAP;
      for (int j = 0; j < 8; j++) begin
         k = (m_pos + j) % l;
         w[31-4*j -: 4] = (k < m_msg.size()) ? m_msg[k] : 4'hA;
      end
      return w;
   endfunction

   function automatic void model_clear();
      m_msg.delete();
      m_show   = 0;
      m_paused = 0;
      m_pos    = 0;
      m_cnt    = 0;
   endfunction

   // Model: advances on every rising edge using the inputs the DUT samples.
   initial forever begin
      exp_t e;
      @(posedge clk);
      if (rst || flush || !m_show) e = '{digits: 32'hAAAA_AAAA, fv: 1'b0};
      else                         e = '{digits: model_window(), fv: 1'b1};
      if (m_known) exp_q.push_back(e);
      if (rst) begin
         m_known = 1;
         model_clear();
      end else if (flush) begin
         model_clear();
      end else if (!m_show) begin
         if (in_valid) begin
            m_msg.push_back((in_digit > 4'd9) ? 4'hA : in_digit);
            if (in_last || m_msg.size() == MAX_LEN) begin
               m_show = 1;
               m_pos  = 0;
               m_cnt  = 0;
            end
         end
      end else if (!m_paused) begin
         if (!run) m_paused = 1;
         else if (m_cnt == TICK_DIV - 1) begin
            m_cnt = 0;
            m_pos = (m_pos + 1) % (m_msg.size() + GAP);
         end else begin
            m_cnt++;
         end
      end else if (run) begin
         m_paused = 0;
      end
   end

   // Monitor: registered outputs from the scoreboard, in_ready from model state.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("digits_out", digits_out, e.digits);
         check("frame_valid", {31'b0, frame_valid}, {31'b0, e.fv});
      end
      if (m_known) check("in_ready", {31'b0, in_ready}, {31'b0, !m_show && !flush});
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic beat(input logic [3:0] d, input logic last);
      in_valid = 1'b1;
      in_digit = d;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic load_1023();
      beat(4'd1, 1'b0);
      beat(4'd0, 1'b0);
      beat(4'd2, 1'b0);
      beat(4'd3, 1'b1);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_digit = 4'd0;
      in_last  = 1'b0;
      run      = 1'b1;
      flush    = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Four-digit message, free scrolling
      load_1023();
      repeat (20) step();

      // Pause for ten cycles mid-count, then resume
      repeat (2) step();
      run = 1'b0;
      repeat (10) step();
      run = 1'b1;
      repeat (12) step();
      do_flush();

      // Flush coinciding with a tick and an offered beat
      load_1023();
      repeat (3) step();
      flush    = 1'b1;
      in_valid = 1'b1;
      in_digit = 4'd5;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      step();
      beat(4'd9, 1'b1);
      repeat (6) step();
      do_flush();

      // Sixteen beats without in_last, plus a seventeenth that must be refused
      for (int i = 0; i < 17; i++) beat(4'($urandom_range(0, 15)), 1'b0);
      repeat (20) step();
      do_flush();

      // Reset in the middle of a load, then a single-digit message
      beat(4'd4, 1'b0);
      beat(4'd5, 1'b0);
      beat(4'd6, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      beat(4'd7, 1'b1);
      repeat (10) step();
      do_flush();

      // Random messages, run toggling, stray beats, occasional flush/reset
      for (int it = 0; it < 40; it++) begin
         int n;
         int cyc;
         n   = $urandom_range(1, MAX_LEN + 2);
         run = 1'b1;
         for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, 2)) step();
            beat(4'($urandom_range(0, 15)), (b == n - 1) && ($urandom_range(0, 3) != 0));
         end
         cyc = $urandom_range(5, 60);
         for (int c = 0; c < cyc; c++) begin
            run      = ($urandom_range(0, 7) != 0);
            in_valid = ($urandom_range(0, 3) == 0);
            in_digit = 4'($urandom_range(0, 15));
            flush    = ($urandom_range(0, 63) == 0);
            step();
         end
         in_valid = 1'b0;
         flush    = 1'b0;
         if ($urandom_range(0, 4) == 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end else begin
            do_flush();
         end
      end

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
